// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller:
// FSM states, ALU control codes, Op field values and datapath mux selects.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the instruction register fields and the datapath control
// inputs. No handshake: the IR fields are levels held stable by the IR, and
// every control output is a level valid for the current cycle only.
interface multicycle_controller_if;
  import arm_ctrl_pkg::*;

  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;

  logic       IRWrite;
  logic       NextPC;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;
  logic [1:0] FlagW;
  logic       RegW;
  logic       MemW;
  logic       PCS;
  logic       instr_done;
  state_t     state_dbg;

  modport master (
    output Op, Funct, Rd,
    input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
           RegSrc, ALUControl, FlagW, RegW, MemW, PCS, instr_done, state_dbg
  );

  modport slave (
    input  Op, Funct, Rd,
    output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
           RegSrc, ALUControl, FlagW, RegW, MemW, PCS, instr_done, state_dbg
  );

endinterface

// File: rtl/alu_decoder.sv
// Maps the data-processing cmd field to an ALU operation and flag-write
// requests; unsupported commands fall back to ADD without touching flags.
module alu_decoder
  import arm_ctrl_pkg::*;
(
  input  logic       aluop_i,
  input  logic [4:0] funct_i,
  output logic [1:0] alu_control_o,
  output logic [1:0] flag_w_o
);

  logic [3:0] cmd;
  assign cmd = funct_i[4:1];

  always_comb begin
    alu_control_o = ALU_ADD;
    flag_w_o      = 2'b00;
    if (aluop_i) begin
      case (cmd)
        CMD_ADD: begin alu_control_o = ALU_ADD; flag_w_o = {funct_i[0], funct_i[0]}; end
        CMD_SUB: begin alu_control_o = ALU_SUB; flag_w_o = {funct_i[0], funct_i[0]}; end
        CMD_AND: begin alu_control_o = ALU_AND; flag_w_o = {funct_i[0], 1'b0}; end
        CMD_ORR: begin alu_control_o = ALU_ORR; flag_w_o = {funct_i[0], 1'b0}; end
        default: begin alu_control_o = ALU_ADD; flag_w_o = 2'b00; end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle ARM-subset datapath. Moore outputs,
// all forced low while reset is asserted; PCS folds in writes to R15.
module multicycle_controller
  import arm_ctrl_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  multicycle_controller_if.slave bus
);

  state_t     state_q, state_d;
  logic       irwrite, nextpc, adrsrc, alusrca, regw, memw, branch, aluop, done;
  logic [1:0] alusrcb, resultsrc, alu_ctrl, flagw;

  alu_decoder u_alu_dec (
    .aluop_i       (aluop),
    .funct_i       (bus.Funct[4:0]),
    .alu_control_o (alu_ctrl),
    .flag_w_o      (flagw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    irwrite   = 1'b0;
    nextpc    = 1'b0;
    adrsrc    = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = SRCB_RD2;
    resultsrc = RES_ALUOUT;
    regw      = 1'b0;
    memw      = 1'b0;
    branch    = 1'b0;
    aluop     = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURESULT;
        irwrite   = 1'b1;
        nextpc    = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURESULT;
        case (bus.Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          // Op=11 is undefined: retire as a two-cycle NOP.
          default: begin state_d = S_FETCH; done = 1'b1; end
        endcase
      end
      S_MEMADR: begin
        alusrcb = SRCB_IMM;
        state_d = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = RES_DATA;
        regw      = 1'b1;
        done      = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc = 1'b1;
        memw   = 1'b1;
        done   = 1'b1;
      end
      S_EXECUTER: begin
        aluop   = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrcb = SRCB_IMM;
        aluop   = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regw = 1'b1;
        done = 1'b1;
      end
      S_BRANCH: begin
        alusrcb   = SRCB_IMM;
        resultsrc = RES_ALURESULT;
        branch    = 1'b1;
        done      = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.IRWrite    = rst & irwrite;
  assign bus.NextPC     = rst & nextpc;
  assign bus.AdrSrc     = rst & adrsrc;
  assign bus.ALUSrcA    = rst & alusrca;
  assign bus.ALUSrcB    = {2{rst}} & alusrcb;
  assign bus.ResultSrc  = {2{rst}} & resultsrc;
  assign bus.ImmSrc     = {2{rst}} & bus.Op;
  assign bus.RegSrc     = {2{rst}} & {bus.Op == OP_MEM, bus.Op == OP_BR};
  assign bus.ALUControl = {2{rst}} & alu_ctrl;
  assign bus.FlagW      = {2{rst}} & flagw;
  assign bus.RegW       = rst & regw;
  assign bus.MemW       = rst & memw;
  assign bus.PCS        = rst & (((bus.Rd == 4'hF) & regw) | branch);
  assign bus.instr_done = rst & done;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a table of instructions expanded by a
// reference sequencer into per-cycle control words, plus reset corner cases.
module tb_multicycle_controller;
  import arm_ctrl_pkg::*;

  localparam int W = 20;

  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic [1:0] aluctrl;
    logic [1:0] flagw;
    logic       regw;
    logic       memw;
    logic       pcs;
    logic       done;
  } ctrl_t;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [1:0] aluctrl;
    logic [1:0] flagw;
    int         cycles;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ctrl_t dut_word;
  assign dut_word = {bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB,
                     bus.ResultSrc, bus.ImmSrc, bus.RegSrc, bus.ALUControl, bus.FlagW,
                     bus.RegW, bus.MemW, bus.PCS, bus.instr_done};

  logic [W-1:0] exp_q[$];
  vec_t         vecs[$];
  int           checks   = 0;
  int           failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [1:0] op, input logic [5:0] funct,
                         input logic [3:0] rd, input logic [1:0] aluctrl,
                         input logic [1:0] flagw, input int cycles);
    vec_t v;
    v.name = name; v.op = op; v.funct = funct; v.rd = rd;
    v.aluctrl = aluctrl; v.flagw = flagw; v.cycles = cycles;
    vecs.push_back(v);
  endtask

  // Reference sequencer: expands one instruction into its per-cycle words.
  function automatic void push_seq(input vec_t v);
    ctrl_t base, c;
    base        = '0;
    base.immsrc = v.op;
    base.regsrc = {v.op == 2'b01, v.op == 2'b10};
    c = base; c.alusrca = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10;
    c.irwrite = 1'b1; c.nextpc = 1'b1;
    exp_q.push_back(c);
    c = base; c.alusrca = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10;
    c.done = (v.op == 2'b11);
    exp_q.push_back(c);
    case (v.op)
      2'b01: begin
        c = base; c.alusrcb = 2'b01;
        exp_q.push_back(c);
        if (v.funct[0]) begin
          c = base; c.adrsrc = 1'b1;
          exp_q.push_back(c);
          c = base; c.resultsrc = 2'b01; c.regw = 1'b1; c.done = 1'b1;
          c.pcs = (v.rd == 4'hF);
          exp_q.push_back(c);
        end else begin
          c = base; c.adrsrc = 1'b1; c.memw = 1'b1; c.done = 1'b1;
          exp_q.push_back(c);
        end
      end
      2'b00: begin
        c = base; c.alusrcb = v.funct[5] ? 2'b01 : 2'b00;
        c.aluctrl = v.aluctrl; c.flagw = v.flagw;
        exp_q.push_back(c);
        c = base; c.regw = 1'b1; c.done = 1'b1; c.pcs = (v.rd == 4'hF);
        exp_q.push_back(c);
      end
      2'b10: begin
        c = base; c.alusrcb = 2'b01; c.resultsrc = 2'b10; c.pcs = 1'b1; c.done = 1'b1;
        exp_q.push_back(c);
      end
      default: ;
    endcase
  endfunction

  // Entered at a falling edge with the DUT in FETCH; leaves at the falling
  // edge of the next FETCH.
  task automatic run_instr(input vec_t v);
    ctrl_t exp_w, act_w;
    int    cyc;
    bit    seen_done;
    bus.Op = v.op; bus.Funct = v.funct; bus.Rd = v.rd;
    push_seq(v);
    cyc = 0;
    seen_done = 1'b0;
    while (!seen_done && cyc < 8) begin
      #1;
      cyc++;
      act_w = dut_word;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s extra_cycle%0d act=%h req=none", v.name, cyc, act_w);
      end else begin
        exp_w = ctrl_t'(exp_q.pop_front());
        chk($sformatf("%s cycle%0d", v.name, cyc), 32'(act_w), 32'(exp_w));
      end
      if (act_w.done) seen_done = 1'b1;
      else @(negedge clk);
    end
    chk({v.name, " latency"}, cyc, v.cycles);
    chk({v.name, " leftover"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic reset_mid(input string name, input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input int adv, input state_t exp_state);
    bus.Op = op; bus.Funct = funct; bus.Rd = rd;
    repeat (adv) @(negedge clk);
    #1;
    chk({name, " pre_state"}, bus.state_dbg, exp_state);
    rst = 1'b0;
    #1;
    chk({name, " outs_zero"}, 32'(dut_word), 32'd0);
    chk({name, " state_fetch"}, bus.state_dbg, S_FETCH);
    @(posedge clk);
    #1;
    chk({name, " held_zero"}, 32'(dut_word), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    add_vec("ldr",        2'b01, 6'b011001, 4'd3,  2'b00, 2'b00, 5);
    add_vec("str",        2'b01, 6'b011000, 4'd3,  2'b00, 2'b00, 4);
    add_vec("ldr_pc",     2'b01, 6'b011001, 4'd15, 2'b00, 2'b00, 5);
    add_vec("adds_reg",   2'b00, 6'b001001, 4'd2,  2'b00, 2'b11, 4);
    add_vec("subs_imm",   2'b00, 6'b100101, 4'd4,  2'b01, 2'b11, 4);
    add_vec("orrs",       2'b00, 6'b011001, 4'd5,  2'b11, 2'b10, 4);
    add_vec("add_nos",    2'b00, 6'b001000, 4'd6,  2'b00, 2'b00, 4);
    add_vec("ands",       2'b00, 6'b000001, 4'd1,  2'b10, 2'b10, 4);
    add_vec("add_pc",     2'b00, 6'b001000, 4'd15, 2'b00, 2'b00, 4);
    add_vec("eors_unsup", 2'b00, 6'b000011, 4'd7,  2'b00, 2'b00, 4);
    add_vec("orr_imm",    2'b00, 6'b111000, 4'd8,  2'b11, 2'b00, 4);
    add_vec("subs_pc",    2'b00, 6'b100101, 4'd15, 2'b01, 2'b11, 4);
    add_vec("branch",     2'b10, 6'b101010, 4'd0,  2'b00, 2'b00, 3);
    add_vec("undef",      2'b11, 6'b010101, 4'd15, 2'b00, 2'b00, 2);

    rst = 1'b0;
    bus.Op = 2'b10; bus.Funct = 6'b111111; bus.Rd = 4'hF;
    @(negedge clk);
    #1;
    chk("reset outs_zero", 32'(dut_word), 32'd0);
    chk("reset state", bus.state_dbg, S_FETCH);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_instr(vecs[i]);

    reset_mid("rst_memread", 2'b01, 6'b011001, 4'd3, 3, S_MEMREAD);
    run_instr(vecs[1]);
    reset_mid("rst_memwrite", 2'b01, 6'b011000, 4'd3, 3, S_MEMWRITE);
    run_instr(vecs[0]);
    reset_mid("rst_aluwb_pc", 2'b00, 6'b001000, 4'hF, 3, S_ALUWB);
    run_instr(vecs[12]);

    for (int i = 0; i < 24; i++) begin
      run_instr(vecs[$urandom_range(0, vecs.size() - 1)]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
